lifo_stack: RTL and testbench

- Parametrised LIFO stack; successor to the fixed 16-bit x 8-entry stack in the datapath.
- Adds the following:
  - configurable width and depth
  - simultaneous push+pop, which replaces the top entry
  - combinational peek of the top entry
  - registered pop data with a valid strobe
  - sticky overflow/underflow error flags
  - synchronous flush
- Used as a call/return-address stack and expression scratch stack next to the core.

---
 rtl/lifo_stack_mem.sv | 35 +++
 rtl/lifo_stack.sv | 156 +++++++++++++++
 tb/tb_lifo_stack.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lifo_stack_mem.sv
// Purpose: DEPTH x DATA_W register array backing the LIFO stack, one write port and one read port.
// Latency: writes land on the next rising edge; reads are combinational from the registered array.
// Backpressure: none; the owner decides when writes are legal and keeps addresses in range.
module lifo_stack_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    // Contents are deliberately not reset: the owner masks reads while the stack is empty.
    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store wdata at waddr; the range guard matters when DEPTH is not a power of two.
    always_ff @(posedge clk) begin
        if (we && (int'(waddr) < DEPTH)) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port with the same range guard so an unused address never reads out of bounds.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < DEPTH) begin
            rdata = mem[raddr];
        end
    end

endmodule

// File: rtl/lifo_stack.sv
// Purpose: parametrised LIFO stack with replace (push+pop), peek, sticky error flags and flush.
// Latency: pop data and its valid strobe are registered and appear 1 cycle after pop_i is sampled.
// Backpressure: none; a push when full is dropped (overflow_o), a pop when empty is flagged (underflow_o).
module lifo_stack #(
    parameter int  DATA_W   = 16,
    parameter int  DEPTH    = 8,
    parameter int  AF_LEVEL = DEPTH - 1,
    localparam int CW       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              flush_i,
    input  logic              clr_err_i,
    output logic [DATA_W-1:0] top_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              almost_full_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    // Array address width; DEPTH >= 2 keeps this at least one bit.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Registered state.
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic [DATA_W-1:0] rd_data_q;
    logic              rd_valid_q;
    logic              overflow_q;
    logic              underflow_q;

    // Decoded request classes (all already masked by flush).
    logic              is_empty;
    logic              is_full;
    logic              push_only;
    logic              pop_only;
    logic              push_pop;
    logic [CW-1:0]     top_idx;

    // Array port signals.
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [AW-1:0]     mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    // Control strobes derived from the decode.
    logic              rd_load;
    logic              overflow_set;
    logic              underflow_set;

    // Decode status and the three request classes; flush suppresses every request this cycle.
    always_comb begin
        is_empty  = (count_q == '0);
        is_full   = (count_q == CW'(DEPTH));
        push_only = !flush_i && push_i && !pop_i;
        pop_only  = !flush_i && pop_i && !push_i;
        push_pop  = !flush_i && push_i && pop_i;
        // Only meaningful when not empty; reads are masked otherwise.
        top_idx   = count_q - CW'(1);
    end

    // Array control: a replace overwrites the current top, any other write appends at count.
    always_comb begin
        mem_we    = (push_only && !is_full) || push_pop;
        mem_waddr = (push_pop && !is_empty) ? AW'(top_idx) : AW'(count_q);
        mem_raddr = is_empty ? '0 : AW'(top_idx);
    end

    // Pop data is captured whenever a pop finds something to return (plain pop or replace).
    always_comb begin
        rd_load       = (pop_only || push_pop) && !is_empty;
        overflow_set  = push_only && is_full;
        underflow_set = (pop_only || push_pop) && is_empty;
    end

    // Next count: a push+pop on an empty stack behaves as a push; guards keep the count in range.
    always_comb begin
        count_d = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_only && !is_full) begin
            count_d = count_q + CW'(1);
        end else if (pop_only && !is_empty) begin
            count_d = count_q - CW'(1);
        end else if (push_pop && is_empty) begin
            count_d = CW'(1);
        end
    end

    lifo_stack_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (push_data_i),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Pop result: strobe is a single cycle; data holds until the next successful pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_load;
            if (rd_load) begin
                rd_data_q <= mem_rdata;
            end
        end
    end

    // Sticky error flags: a new error in the same cycle as a clear leaves the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_set  || (overflow_q  && !clr_err_i);
            underflow_q <= underflow_set || (underflow_q && !clr_err_i);
        end
    end

    // Outputs: status decoded from the count register, peek masked to zero when empty.
    always_comb begin
        top_o         = is_empty ? '0 : mem_rdata;
        rd_data_o     = rd_data_q;
        rd_valid_o    = rd_valid_q;
        count_o       = count_q;
        empty_o       = is_empty;
        full_o        = is_full;
        almost_full_o = (count_q >= CW'(AF_LEVEL));
        overflow_o    = overflow_q;
        underflow_o   = underflow_q;
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Purpose: directed bench for lifo_stack with a scoreboard for popped data and direct status checks.
// Latency: expects pop data one cycle after the pop is sampled, tagged with the exact cycle.
// Backpressure: not applicable; the bench drives requests every cycle as listed.
module tb_lifo_stack;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              push_i;
    logic [DATA_W-1:0] push_data_i;
    logic              pop_i;
    logic              flush_i;
    logic              clr_err_i;
    logic [DATA_W-1:0] top_o;
    logic [DATA_W-1:0] rd_data_o;
    logic              rd_valid_o;
    logic [CW-1:0]     count_o;
    logic              empty_o;
    logic              full_o;
    logic              almost_full_o;
    logic              overflow_o;
    logic              underflow_o;

    lifo_stack #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .push_i        (push_i),
        .push_data_i   (push_data_i),
        .pop_i         (pop_i),
        .flush_i       (flush_i),
        .clr_err_i     (clr_err_i),
        .top_o         (top_o),
        .rd_data_o     (rd_data_o),
        .rd_valid_o    (rd_valid_o),
        .count_o       (count_o),
        .empty_o       (empty_o),
        .full_o        (full_o),
        .almost_full_o (almost_full_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_pop(input logic [DATA_W-1:0] d);
        exp_t e;
        e.data = d;
        e.cyc  = cyc + 1;
        sb.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest expectation, and no expectation may be skipped.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid_o) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL pop_unexpected: strobe with data 0x%0h, none expected (cycle %0d)", rd_data_o, cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (rd_data_o !== e.data || cyc != e.cyc) begin
                        n_err++;
                        $display("FAIL pop_data: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                                 rd_data_o, cyc, e.data, e.cyc);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                n_err++;
                $display("FAIL pop_missing: no strobe, expected 0x%0h at cycle %0d", e.data, e.cyc);
            end
        end
    end

    initial begin
        rst         = 1'b1;
        push_i      = 1'b0;
        push_data_i = '0;
        pop_i       = 1'b0;
        flush_i     = 1'b0;
        clr_err_i   = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state.
        check("rst_count", count_o, 0);
        check("rst_empty", empty_o, 1);
        check("rst_full", full_o, 0);
        check("rst_top", top_o, 0);
        check("rst_valid", rd_valid_o, 0);
        check("rst_ovf", overflow_o, 0);
        check("rst_unf", underflow_o, 0);
        tick();
        check("idle_count", count_o, 0);

        // Fill: 0x1111 .. 0x8888.
        for (int i = 1; i <= 8; i++) begin
            push_i      = 1'b1;
            push_data_i = DATA_W'(16'h1111 * i);
            tick();
            check("fill_count", count_o, i);
            check("fill_top", top_o, 16'h1111 * i);
            check("fill_af", almost_full_o, (i >= 7) ? 1 : 0);
        end
        check("fill_full", full_o, 1);

        // Ninth push is dropped.
        push_data_i = 16'h9999;
        tick();
        push_i = 1'b0;
        check("ovf_count", count_o, 8);
        check("ovf_flag", overflow_o, 1);
        check("ovf_top", top_o, 16'h8888);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        check("ovf_clr", overflow_o, 0);

        // Drain: 0x8888 down to 0x1111.
        for (int i = 8; i >= 1; i--) begin
            pop_i = 1'b1;
            expect_pop(DATA_W'(16'h1111 * i));
            tick();
            check("drain_count", count_o, i - 1);
        end
        pop_i = 1'b0;
        check("drain_empty", empty_o, 1);
        check("drain_top", top_o, 0);
        tick();

        // Pop while empty.
        pop_i = 1'b1;
        tick();
        pop_i = 1'b0;
        check("unf_flag", underflow_o, 1);
        check("unf_valid", rd_valid_o, 0);
        check("unf_hold", rd_data_o, 16'h1111);
        check("unf_count", count_o, 0);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        check("unf_clr", underflow_o, 0);

        // Replace on a two-entry stack.
        push_i = 1'b1;
        push_data_i = 16'hAAAA;
        tick();
        push_data_i = 16'hBBBB;
        tick();
        push_data_i = 16'hCCCC;
        pop_i = 1'b1;
        expect_pop(16'hBBBB);
        tick();
        push_i = 1'b0;
        pop_i  = 1'b0;
        check("rep_count", count_o, 2);
        check("rep_top", top_o, 16'hCCCC);
        check("rep_valid", rd_valid_o, 1);
        check("rep_ovf", overflow_o, 0);
        check("rep_unf", underflow_o, 0);

        // Drain the replaced stack.
        pop_i = 1'b1;
        expect_pop(16'hCCCC);
        tick();
        expect_pop(16'hAAAA);
        tick();
        pop_i = 1'b0;
        check("rep_empty", empty_o, 1);

        // Push+pop on an empty stack: the push lands, the pop underflows.
        push_i = 1'b1;
        pop_i  = 1'b1;
        push_data_i = 16'h1234;
        tick();
        push_i = 1'b0;
        pop_i  = 1'b0;
        check("pe_count", count_o, 1);
        check("pe_top", top_o, 16'h1234);
        check("pe_unf", underflow_o, 1);
        check("pe_valid", rd_valid_o, 0);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        check("pe_clr", underflow_o, 0);

        // A new underflow in the same cycle as clear keeps the flag set.
        pop_i = 1'b1;
        expect_pop(16'h1234);
        tick();
        clr_err_i = 1'b1;
        tick();
        pop_i     = 1'b0;
        clr_err_i = 1'b0;
        check("setwin_unf", underflow_o, 1);
        clr_err_i = 1'b1;
        tick();
        clr_err_i = 1'b0;
        check("setwin_clr", underflow_o, 0);

        // Flush with a pop pending at count 5.
        push_i = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_data_i = DATA_W'(i);
            tick();
        end
        push_i = 1'b0;
        check("fl_pre", count_o, 5);
        pop_i   = 1'b1;
        flush_i = 1'b1;
        tick();
        pop_i   = 1'b0;
        flush_i = 1'b0;
        check("fl_count", count_o, 0);
        check("fl_valid", rd_valid_o, 0);
        check("fl_unf", underflow_o, 0);
        check("fl_empty", empty_o, 1);

        // Asynchronous reset right after a pop.
        push_i = 1'b1;
        push_data_i = 16'h0A0A;
        tick();
        push_data_i = 16'h0B0B;
        tick();
        push_i = 1'b0;
        pop_i  = 1'b1;
        tick();
        pop_i  = 1'b0;
        check("ar_pre_valid", rd_valid_o, 1);
        check("ar_pre_data", rd_data_o, 16'h0B0B);
        check("ar_pre_count", count_o, 1);
        #2 rst = 1'b1;
        #1;
        check("ar_valid", rd_valid_o, 0);
        check("ar_count", count_o, 0);
        check("ar_data", rd_data_o, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("ar_after", count_o, 0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
